dump_ctrl: RTL
==============

# dump_ctrl

Readout engine for the capture RAM. After a capture completes, it reads one channel's samples out of the circular buffer in chronological order, starting with the oldest sample. Each byte goes to the UART transmitter through a one-byte `trmt`/`tx_done` handshake. It is the reader on the RAM's port, opposite the capture controller, which writes the buffer.

## Interface
- `DEPTH`, default 512: number of entries in the capture RAM. Must be ≥ 2.
- `ADDR_W`, default 9: RAM address width. Requires 2^ADDR_W ≥ DEPTH.
- `DATA_W`, default 8: sample width. Also the UART byte width.

Ports:
- `clk` input, 1: system clock.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `dump_start` input, 1: one-cycle request to dump channel `dump_ch`.
- `dump_ch` input, 2: channel to dump. Sampled on the accepted `dump_start`.
- `capture_valid` input, 1: high when the buffer holds a complete capture.
- `trace_end` input, ADDR_W: address of the newest sample written. Sampled on the accepted `dump_start`.
- `ram_en` output, 1: RAM read enable.
- `ram_addr` output, ADDR_W: RAM read address.
- `ram_ch` output, 2: channel select to the RAM bank.
- `ram_rdata` input, DATA_W: read data, valid exactly one cycle after `ram_en`.
- `tx_data` output, DATA_W: byte presented to the UART.
- `trmt` output, 1: one-cycle transmit strobe.
- `tx_done` input, 1: UART has finished the current byte.
- `dump_busy` output, 1: dump in progress.
- `dump_done` output, 1: one-cycle pulse after the final byte completes.
- `dump_err` output, 1: one-cycle pulse when `dump_start` arrives while `capture_valid` is low.

## Operation

State machine states: IDLE, RD, LOAD, SEND, WAIT (plus HDR, see Configuration).

- **IDLE**
  - On `dump_start` with `capture_valid` high: latch the channel and the start address into registers, clear the byte counter, go to RD.
  - Start address is `trace_end+1`, wrapping `DEPTH-1` to 0.
  - On `dump_start` with `capture_valid` low: pulse `dump_err`, stay in IDLE.
- **RD:** `ram_en`=1, `ram_addr`=current address. Go to LOAD.
- **LOAD:** register `ram_rdata` into `tx_data`. Go to SEND.
- **SEND:** `trmt`=1 for exactly one cycle. Go to WAIT.
- **WAIT:** hold `tx_data` stable until `tx_done`=1. When `tx_done` is seen:
  - If the counter equals `DEPTH-1`: pulse `dump_done`, go to IDLE.
  - Otherwise: increment the counter, increment the address (wrapping `DEPTH-1` to 0), go to RD.
- Exactly DEPTH sample bytes are sent per dump, oldest first. The last byte sent is the one at `trace_end`.
- `dump_busy`=1 in every state except IDLE.
- `dump_start` is ignored while busy.
- `tx_done` is ignored outside WAIT and HDR. A `tx_done` in the same cycle as `trmt` is ignored.
- `capture_valid` dropping mid-dump has no effect; the dump completes.
- Asserting `rst_n` low mid-dump aborts immediately: return to IDLE with no `dump_done`.
- Reset values:
  - State IDLE.
  - `ram_en`=0, `ram_addr`=0, `ram_ch`=0.
  - `tx_data`=0, `trmt`=0.
  - `dump_busy`=0, `dump_done`=0, `dump_err`=0.
  - Counter and address registers 0.

## Timing
- `dump_start` accepted at edge 0:
  - `ram_en` high in cycle 1.
  - `tx_data` valid from cycle 3.
  - `trmt` high in cycle 3.
- `tx_done` seen in cycle N (not the last byte): `ram_en` in N+1, `trmt` in N+3.
- `tx_done` for the last byte seen in cycle N: `dump_done` high in N+1, `dump_busy` low in N+1.
- All outputs are registered or decoded from state only. No combinational path from `tx_done` to `trmt`.
- RAM read latency is fixed at 1. `ram_rdata` is sampled only in LOAD.

## Configuration
- `DUMP_HEADER_EN` defined:
  - After an accepted start, go to HDR instead of RD.
  - In HDR, `tx_data`=`8'hA0 | dump_ch` (zero-extended to DATA_W), with `trmt` high on the first HDR cycle.
  - On `tx_done`, go to RD.
  - A dump is then DEPTH+1 bytes. First `trmt` in cycle 1; first `ram_en` the cycle after the header's `tx_done`.
- `DUMP_HEADER_EN` undefined: no HDR state; behaviour exactly as described above.

## Test plan
- **Basic dump:** DEPTH=8, RAM[i]=i+0x10, `trace_end`=3, UART model returns `tx_done` 4 cycles after `trmt`. Expect bytes 0x14,0x15,0x16,0x17,0x10,0x11,0x12,0x13, then one `dump_done` pulse.
- **Wrap boundary:** `trace_end`=7 (DEPTH-1). Expect the first read at address 0 and the last at 7; addresses 0..7 seen exactly once.
- **Error path:** `dump_start` with `capture_valid`=0. Expect `dump_err` high for 1 cycle, `dump_busy` stays 0, `ram_en` never asserts.
- **Ignored inputs:** re-pulse `dump_start` mid-dump and drive `tx_done` during SEND. Expect the byte sequence and count unchanged, with exactly 8 `trmt` pulses.
- **Reset mid-op:** pull `rst_n` low after the 3rd byte. Expect all outputs at reset values, and no `dump_done`. A new start then dumps all 8 bytes correctly.
- **Header option:** with `DUMP_HEADER_EN`, `dump_ch`=2. Expect first byte 0xA2, then the 8 samples, for 9 `trmt` pulses total.

Source files
------------

// File: rtl/dump_ctrl.sv
// rtl/dump_ctrl.sv - capture RAM readout engine feeding the UART byte handshake
// Optional feature: define DUMP_HEADER_EN to prefix each dump with a 0xA0|channel header byte.
module dump_ctrl #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_start_i,
    input  logic [1:0]        dump_ch_i,
    input  logic              capture_valid_i,
    input  logic [ADDR_W-1:0] trace_end_i,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [1:0]        ram_ch_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              trmt_o,
    input  logic              tx_done_i,
    output logic              dump_busy_o,
    output logic              dump_done_o,
    output logic              dump_err_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_HDR
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   start_addr_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [1:0]          ch_q;
    logic                ram_en_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                trmt_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

`ifdef DUMP_HEADER_EN
    logic [DATA_W-1:0]   hdr_byte;
    assign hdr_byte = DATA_W'({6'b101000, dump_ch_i});
`endif

    // Circular-buffer address arithmetic: oldest sample sits just after trace_end.
    always_comb begin
        start_addr_d = (trace_end_i == LAST) ? '0 : trace_end_i + ADDR_W'(1);
        next_addr_d  = (addr_q == LAST) ? '0 : addr_q + ADDR_W'(1);
    end

    // Readout sequencer: read, load, strobe, wait for the UART, repeat DEPTH times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            ch_q      <= '0;
            ram_en_q  <= 1'b0;
            tx_data_q <= '0;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            trmt_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ram_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dump_start_i) begin
                        if (capture_valid_i) begin
                            ch_q   <= dump_ch_i;
                            addr_q <= start_addr_d;
                            cnt_q  <= '0;
                            busy_q <= 1'b1;
`ifdef DUMP_HEADER_EN
                            tx_data_q <= hdr_byte;
                            trmt_q    <= 1'b1;
                            state_q   <= S_HDR;
`else
                            ram_en_q <= 1'b1;
                            state_q  <= S_RD;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    // A tx_done coincident with the header strobe belongs to no byte.
                    if (tx_done_i && !trmt_q) begin
                        ram_en_q <= 1'b1;
                        state_q  <= S_RD;
                    end
                end
                S_RD: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    tx_data_q <= ram_rdata_i;
                    trmt_q    <= 1'b1;
                    state_q   <= S_SEND;
                end
                S_SEND: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done_i) begin
                        if (cnt_q == LAST) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q    <= cnt_q + ADDR_W'(1);
                            addr_q   <= next_addr_d;
                            ram_en_q <= 1'b1;
                            state_q  <= S_RD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ram_en_o    = ram_en_q;
    assign ram_addr_o  = addr_q;
    assign ram_ch_o    = ch_q;
    assign tx_data_o   = tx_data_q;
    assign trmt_o      = trmt_q;
    assign dump_busy_o = busy_q;
    assign dump_done_o = done_q;
    assign dump_err_o  = err_q;

endmodule
